fft_peak_detect: RTL

- Downstream stage of the FFT core. Consumes the complex output stream, one bin per cycle in natural bin order 0..N-1, each word packed {re, im}.
- Computes the squared magnitude of every bin and finds the largest bin in the positive-frequency half (bins 0..N/2-1).
- Presents the peak bin index and its magnitude on a valid/ready result interface.
- Used for tone detection at the tail of the spectral pipeline.

---
 rtl/fft_peak_detect_if.sv | 42 ++++
 rtl/fft_peak_detect.sv | 138 +++++++++++++
 2 files changed

// File: rtl/fft_peak_detect_if.sv
// fft_peak_detect_if: FFT bin stream in, peak result out, optional per-bin magnitude tap.
// Ports: in_valid/in_data/in_ready (bins), result_valid/result_ready/peak_bin/peak_mag,
//        overflow; mag_valid/mag_data/mag_bin only when FFT_PEAK_MAG_STREAM_EN is defined.
// master = environment side (drives bins and result_ready), slave = fft_peak_detect.
interface fft_peak_detect_if #(
    parameter int width = 16,
    parameter int N_2   = 5
);
    logic               in_valid;
    logic [2*width-1:0] in_data;
    logic               in_ready;
    logic               result_valid;
    logic               result_ready;
    logic [N_2-2:0]     peak_bin;
    logic [2*width-1:0] peak_mag;
    logic               overflow;
`ifdef FFT_PEAK_MAG_STREAM_EN
    logic               mag_valid;
    logic [2*width-1:0] mag_data;
    logic [N_2-1:0]     mag_bin;

    modport master (
        output in_valid, in_data, result_ready,
        input  in_ready, result_valid, peak_bin, peak_mag, overflow,
        input  mag_valid, mag_data, mag_bin
    );
    modport slave (
        input  in_valid, in_data, result_ready,
        output in_ready, result_valid, peak_bin, peak_mag, overflow,
        output mag_valid, mag_data, mag_bin
    );
`else
    modport master (
        output in_valid, in_data, result_ready,
        input  in_ready, result_valid, peak_bin, peak_mag, overflow
    );
    modport slave (
        input  in_valid, in_data, result_ready,
        output in_ready, result_valid, peak_bin, peak_mag, overflow
    );
`endif
endinterface

// File: rtl/fft_peak_detect.sv
// fft_peak_detect: squared magnitude per FFT bin, largest bin in the positive half
//   (bins 0..N/2-1, bin 0 skipped when SKIP_DC=1) presented on a valid/ready result port.
// Latency: result_valid rises 3 edges after the edge accepting bin N-1.
// Backpressure: in_ready drops from frame end until the result is taken; words offered
//   meanwhile are dropped and set sticky overflow. Ports: clk, reset, bus (slave modport).
// Optional FFT_PEAK_MAG_STREAM_EN adds mag_valid/mag_data/mag_bin (per-bin magnitude tap).
module fft_peak_detect #(
    parameter int width   = 16,
    parameter int N_2     = 5,
    parameter int SKIP_DC = 1
) (
    input  logic             clk,
    input  logic             reset,
    fft_peak_detect_if.slave bus
);
    localparam logic [N_2-2:0] FIRST_BIN = (N_2-1)'(SKIP_DC != 0 ? 1 : 0);

    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, HOLD} state_t;

    state_t                    state, state_nxt;
    logic                      in_ready;
    logic                      result_valid;
    logic                      accept;
    logic [N_2-1:0]            bin_cnt;
    logic signed [width-1:0]   re, im;

    // Stage 1: squared components; stage 2: magnitude.
    logic                      s1_vld;
    logic signed [2*width-1:0] s1_re2, s1_im2;
    logic [N_2-1:0]            s1_bin;
    logic                      s2_vld;
    logic [2*width-1:0]        s2_mag;
    logic [N_2-1:0]            s2_bin;
    logic                      s2_eligible;

    logic [N_2-2:0]            peak_bin;
    logic [2*width-1:0]        peak_mag;
    logic                      overflow;

    assign re     = bus.in_data[2*width-1:width];
    assign im     = bus.in_data[width-1:0];
    assign accept = bus.in_valid & in_ready;

    // Positive half means the index MSB is clear.
    assign s2_eligible = !s2_bin[N_2-1] && ((s2_bin != '0) || (SKIP_DC == 0));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        in_ready     = 1'b0;
        result_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (bus.in_valid) state_nxt = ACCUM;
            end
            ACCUM: begin
                in_ready = 1'b1;
                if (bus.in_valid && (bin_cnt == {N_2{1'b1}})) state_nxt = DRAIN;
            end
            DRAIN: begin
                // Both stages empty means the last bin has reached the peak registers.
                if (!s1_vld && !s2_vld) state_nxt = HOLD;
            end
            HOLD: begin
                result_valid = 1'b1;
                if (bus.result_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Counter wraps to 0 naturally on the accept of bin N-1.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)       bin_cnt <= '0;
        else if (accept) bin_cnt <= bin_cnt + {{(N_2-1){1'b0}}, 1'b1};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_vld <= 1'b0;
            s1_re2 <= '0;
            s1_im2 <= '0;
            s1_bin <= '0;
            s2_vld <= 1'b0;
            s2_mag <= '0;
            s2_bin <= '0;
        end else begin
            s1_vld <= accept;
            if (accept) begin
                s1_re2 <= re * re;
                s1_im2 <= im * im;
                s1_bin <= bin_cnt;
            end
            s2_vld <= s1_vld;
            if (s1_vld) begin
                // Both squares are non-negative and at most 2^(2*width-2): sum cannot wrap.
                s2_mag <= $unsigned(s1_re2) + $unsigned(s1_im2);
                s2_bin <= s1_bin;
            end
        end
    end

    // Strict compare keeps the lowest index on ties.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            peak_mag <= '0;
            peak_bin <= FIRST_BIN;
        end else if (result_valid && bus.result_ready) begin
            peak_mag <= '0;
            peak_bin <= FIRST_BIN;
        end else if (s2_vld && s2_eligible && (s2_mag > peak_mag)) begin
            peak_mag <= s2_mag;
            peak_bin <= s2_bin[N_2-2:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                        overflow <= 1'b0;
        else if (bus.in_valid && !in_ready) overflow <= 1'b1;
    end

    assign bus.in_ready     = in_ready;
    assign bus.result_valid = result_valid;
    assign bus.peak_bin     = peak_bin;
    assign bus.peak_mag     = peak_mag;
    assign bus.overflow     = overflow;

`ifdef FFT_PEAK_MAG_STREAM_EN
    assign bus.mag_valid = s2_vld;
    assign bus.mag_data  = s2_mag;
    assign bus.mag_bin   = s2_bin;
`endif
endmodule
